calc_pipe: RTL and testbench
============================

# calc_pipe

Parametrised successor to the single-entry calculator. Accepts one operation per cycle on a valid/stall input handshake and executes add/sub/mul in one cycle and divide iteratively over W cycles. Results are buffered in a DEPTH-entry in-order output FIFO drained by a valid/stall output handshake. Sits between an operand producer and a result consumer, and decouples them under backpressure.

## Interface
- W, 8: operand width; result width is 2W (W >= 2)
- DEPTH, 4: output FIFO entries; power of two, >= 2
- clk  in  1  clock; all state on rising edge
- rstn  in  1  reset, asynchronous assert, active-low; one clock, async active-low reset (as decided)
- inpA  in  W  operand A, unsigned
- inpB  in  W  operand B, unsigned
- inpOpType  in  2  00 add, 01 sub, 10 mul, 11 div
- iValid  in  1  input operation present
- iStall  out  1  block cannot accept this cycle
- outC  out  2W  result at FIFO head
- outErr  out  1  head result is a divide-by-zero
- oValid  out  1  FIFO head valid
- oStall  in  1  consumer cannot take head this cycle

## Operation
- Input transfer: iValid && !iStall at a rising edge. Operands and op are latched into the single exec stage. iValid while iStall is ignored; the producer holds.
- Output transfer: oValid && !oStall at an edge pops the head. Entries leave in acceptance order.
- Exec states:
  - IDLE: empty.
  - EXEC: one cycle, computes and pushes at the end of the cycle, then returns to IDLE, or reloads if a new op is accepted the same edge.
  - DIV: restoring divide, one quotient bit per cycle, iter counter 0..W-1, pushes on iteration W-1.
- Arithmetic (2W-bit result):
  - add: zero-extended A+B.
  - sub: (A-B) mod 2^(2W).
  - mul: full A*B.
  - div: {remainder[W-1:0], quotient[W-1:0]}.
- Divide by zero is detected on latch: EXEC path (no DIV state), pushes result 0 with err=1. All other results have err=0.
- iStall = (state==DIV && iter!=W-1) || (fifo_count + exec_occupied >= DEPTH). It is combinational from registers only, with no path from iValid or oStall.
- Space reservation guarantees every exec push finds room. The FIFO never overflows and never drops data.
- FIFO push and pop in the same cycle are allowed; count is unchanged. Read and write pointers wrap modulo DEPTH.
- outC/outErr are forced to 0 while oValid=0. They are stable while oValid && oStall.
- Reset (any time, including mid-divide or with a full FIFO): state IDLE, iter 0, FIFO count and pointers 0, in-flight op discarded. FIFO data RAM is not reset.

## Timing
- Reset values: iStall=0, oValid=0, outC=0, outErr=0.
- add/sub/mul/div-by-zero accepted at edge t: push at edge t+1, oValid from t+1 (latency 2 cycles from the iValid cycle) if the FIFO was empty.
- div (B!=0) accepted at edge t: iterations in cycles after t, push at edge t+W, oValid from t+W.
- Throughput with oStall=0:
  - Non-div ops: 1 per cycle sustained.
  - Div: 1 per W cycles. iStall deasserts in the final iteration cycle so the next op loads on the push edge.
- oStall=1 continuously: at most DEPTH ops accepted; then iStall=1 until a pop.
- iStall reacts to a pop one cycle after the pop edge (conservative, count-based).

## Test plan
- Reset, then iValid add A=200 B=100 at edge 1 -> oValid at edge 2, outC=0x012C, outErr=0; all outputs 0 during reset.
- Back-to-back sub 5-7, mul 255*255, add 1+1, oStall=0 -> outC 0xFFFE, 0xFE01, 0x0002 on consecutive cycles, iStall never high.
- div 200/7 at edge t -> iStall high cycles t..t+6, push at t+8, outC=0x041C; a following add accepted on edge t+8.
- div 9/0 -> latency 2, outC=0x0000, outErr=1; the next op's outErr=0.
- oStall=1, iValid=1 with 6 adds -> exactly 4 accepted, iStall=1. Release oStall -> 4 results in order, remaining 2 then accepted.
- Assert rstn low mid-divide with 3 FIFO entries -> oValid=0 and iStall=0 immediately. After release, the next op completes normally with no stale results.

Source files
------------

// File: rtl/calc_pipe.sv
// calc_pipe: one-cycle add/sub/mul and W-cycle restoring divide,
// results queued in a DEPTH-entry in-order FIFO with valid/stall handshakes.
module calc_pipe #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic [W-1:0]   inpA,
   input  logic [W-1:0]   inpB,
   input  logic [1:0]     inpOpType,
   input  logic           iValid,
   output logic           iStall,
   output logic [2*W-1:0] outC,
   output logic           outErr,
   output logic           oValid,
   input  logic           oStall
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int IW = $clog2(W);

   localparam logic [IW-1:0] LAST = IW'(W - 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      DIV
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [IW-1:0]  iter;
   logic [W-1:0]   a_r;
   logic [W-1:0]   b_r;
   logic [1:0]     op_r;
   logic [W-1:0]   rem_r;

   logic [CW-1:0]  cnt;
   logic [AW-1:0]  wptr;
   logic [AW-1:0]  rptr;

   logic [2*W-1:0] mem_c [DEPTH];
   logic           mem_e [DEPTH];

   logic           occ;
   logic [CW-1:0]  fill;
   logic           last_div;
   logic           accept;
   logic           pop;
   logic           push;
   logic [2*W-1:0] res;
   logic           res_err;

   logic [W:0]     shifted;
   logic           ge;
   logic [W-1:0]   rem_n;
   logic [W-1:0]   quo_n;

   logic [2*W-1:0] ext_a;
   logic [2*W-1:0] ext_b;

   // Stall counts the in-flight op as already holding a FIFO slot,
   // so every push is guaranteed room.
   assign occ      = (state != IDLE);
   assign fill     = cnt + CW'(occ);
   assign last_div = (state == DIV) && (iter == LAST);
   assign iStall   = ((state == DIV) && !last_div) || (fill >= FULL);
   assign accept   = iValid && !iStall;

   assign oValid   = (cnt != '0);
   assign pop      = oValid && !oStall;
   assign outC     = oValid ? mem_c[rptr] : '0;
   assign outErr   = oValid ? mem_e[rptr] : 1'b0;

   // a_r doubles as the quotient shift register while dividing
   assign shifted  = {rem_r, a_r[W-1]};
   assign ge       = (shifted >= {1'b0, b_r});
   assign rem_n    = ge ? (shifted[W-1:0] - b_r) : shifted[W-1:0];
   assign quo_n    = {a_r[W-2:0], ge};

   assign ext_a    = {{W{1'b0}}, a_r};
   assign ext_b    = {{W{1'b0}}, b_r};

   always_comb begin
      push    = 1'b0;
      res     = '0;
      res_err = 1'b0;
      unique case (1'b1)
         (state == EXEC): begin
            push = 1'b1;
            unique case (op_r)
               OP_ADD:  res = ext_a + ext_b;
               OP_SUB:  res = ext_a - ext_b;
               OP_MUL:  res = ext_a * ext_b;
               default: res_err = 1'b1;
            endcase
         end
         (state == DIV): begin
            push = last_div;
            res  = {rem_n, quo_n};
         end
         default: begin
            push = 1'b0;
         end
      endcase
   end

   always_comb begin
      state_nxt = state;
      if (accept) begin
         if ((inpOpType == OP_DIV) && (inpB != '0)) begin
            state_nxt = DIV;
         end else begin
            state_nxt = EXEC;
         end
      end else if (push) begin
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         iter  <= '0;
         a_r   <= '0;
         b_r   <= '0;
         op_r  <= OP_ADD;
         rem_r <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            a_r   <= inpA;
            b_r   <= inpB;
            op_r  <= inpOpType;
            rem_r <= '0;
            iter  <= '0;
         end else if (state == DIV) begin
            a_r   <= quo_n;
            rem_r <= rem_n;
            iter  <= iter + IW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt  <= '0;
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + AW'(1);
         end
         if (pop) begin
            rptr <= rptr + AW'(1);
         end
         if (push && !pop) begin
            cnt <= cnt + CW'(1);
         end else if (pop && !push) begin
            cnt <= cnt - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_c[wptr] <= res;
         mem_e[wptr] <= res_err;
      end
   end

endmodule

// File: tb/tb_calc_pipe.sv
// Directed self-checking bench for calc_pipe (W=8, DEPTH=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_calc_pipe;

   logic        clk;
   logic        rstn;
   logic [7:0]  inpA;
   logic [7:0]  inpB;
   logic [1:0]  inpOpType;
   logic        iValid;
   logic        iStall;
   logic [15:0] outC;
   logic        outErr;
   logic        oValid;
   logic        oStall;

   int checks = 0;
   int errors = 0;
   int idx;
   int got;
   logic acc;

   calc_pipe #(.W(8), .DEPTH(4)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .inpA      (inpA),
      .inpB      (inpB),
      .inpOpType (inpOpType),
      .iValid    (iValid),
      .iStall    (iStall),
      .outC      (outC),
      .outErr    (outErr),
      .oValid    (oValid),
      .oStall    (oStall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b);
      inpOpType = op;
      inpA      = a;
      inpB      = b;
      iValid    = 1'b1;
   endtask

   initial begin
      rstn      = 1'b0;
      inpA      = '0;
      inpB      = '0;
      inpOpType = '0;
      iValid    = 1'b0;
      oStall    = 1'b0;
      #12;
      chk("rst_istall", iStall, 0);
      chk("rst_ovalid", oValid, 0);
      chk("rst_outc", outC, 0);
      chk("rst_outerr", outErr, 0);
      tick;
      rstn = 1'b1;

      // add 200+100
      drive(2'b00, 8'd200, 8'd100);
      tick;
      iValid = 1'b0;
      chk("add_lat_ovalid0", oValid, 0);
      tick;
      chk("add_ovalid", oValid, 1);
      chk("add_outc", outC, 16'h012C);
      chk("add_err", outErr, 0);
      tick;
      chk("add_drain", oValid, 0);

      // back-to-back sub, mul, add
      chk("b2b_istall0", iStall, 0);
      drive(2'b01, 8'd5, 8'd7);
      tick;
      chk("b2b_istall1", iStall, 0);
      drive(2'b10, 8'd255, 8'd255);
      tick;
      chk("b2b_istall2", iStall, 0);
      chk("sub_outc", outC, 16'hFFFE);
      drive(2'b00, 8'd1, 8'd1);
      tick;
      iValid = 1'b0;
      chk("mul_outc", outC, 16'hFE01);
      tick;
      chk("add11_outc", outC, 16'h0002);
      tick;
      chk("b2b_drain", oValid, 0);

      // div 200/7, add 3+4 held by producer during the divide
      drive(2'b11, 8'd200, 8'd7);
      tick;
      drive(2'b00, 8'd3, 8'd4);
      for (int i = 0; i < 7; i++) begin
         chk("div_istall_hi", iStall, 1);
         chk("div_ovalid0", oValid, 0);
         tick;
      end
      chk("div_istall_lo", iStall, 0);
      chk("div_ovalid_last", oValid, 0);
      tick;
      iValid = 1'b0;
      chk("div_ovalid", oValid, 1);
      chk("div_outc", outC, 16'h041C);
      chk("div_err", outErr, 0);
      tick;
      chk("div_next_outc", outC, 16'h0007);
      tick;
      chk("div_drain", oValid, 0);

      // divide by zero
      drive(2'b11, 8'd9, 8'd0);
      tick;
      drive(2'b00, 8'd2, 8'd2);
      tick;
      iValid = 1'b0;
      chk("dz_ovalid", oValid, 1);
      chk("dz_outc", outC, 0);
      chk("dz_err", outErr, 1);
      tick;
      chk("dz_next_outc", outC, 16'h0004);
      chk("dz_next_err", outErr, 0);
      tick;
      chk("dz_drain", oValid, 0);

      // backpressure: six adds k+16 with oStall held
      oStall = 1'b1;
      idx    = 0;
      for (int c = 0; c < 10; c++) begin
         if (idx < 6) drive(2'b00, 8'(idx), 8'd16);
         else iValid = 1'b0;
         acc = iValid && !iStall;
         tick;
         if (acc) idx++;
      end
      chk("bp_accepted", idx, 4);
      chk("bp_istall", iStall, 1);
      chk("bp_head", outC, 16'd16);
      tick;
      chk("bp_head_stable", outC, 16'd16);
      chk("bp_istall_held", iStall, 1);
      oStall = 1'b0;
      got    = 0;
      for (int c = 0; c < 40 && got < 6; c++) begin
         if (oValid) begin
            chk("bp_order", outC, 32'(16 + got));
            chk("bp_err", outErr, 0);
            got++;
         end
         if (idx < 6) drive(2'b00, 8'(idx), 8'd16);
         else iValid = 1'b0;
         acc = iValid && !iStall;
         tick;
         if (acc) idx++;
      end
      iValid = 1'b0;
      chk("bp_all_out", got, 6);
      chk("bp_all_in", idx, 6);
      chk("bp_drain", oValid, 0);

      // reset mid-divide with three queued results
      oStall = 1'b1;
      chk("mr_istall_a", iStall, 0);
      drive(2'b00, 8'd1, 8'd0);
      tick;
      chk("mr_istall_b", iStall, 0);
      drive(2'b00, 8'd2, 8'd0);
      tick;
      chk("mr_istall_c", iStall, 0);
      drive(2'b00, 8'd3, 8'd0);
      tick;
      chk("mr_istall_d", iStall, 0);
      drive(2'b11, 8'd200, 8'd7);
      tick;
      iValid = 1'b0;
      tick;
      tick;
      chk("mr_pre_ovalid", oValid, 1);
      chk("mr_pre_istall", iStall, 1);
      #2;
      rstn = 1'b0;
      #1;
      chk("mr_ovalid", oValid, 0);
      chk("mr_istall", iStall, 0);
      chk("mr_outc", outC, 0);
      chk("mr_outerr", outErr, 0);
      tick;
      rstn   = 1'b1;
      oStall = 1'b0;
      drive(2'b00, 8'd7, 8'd8);
      tick;
      iValid = 1'b0;
      chk("mr_post_lat", oValid, 0);
      tick;
      chk("mr_post_ovalid", oValid, 1);
      chk("mr_post_outc", outC, 16'd15);
      tick;
      chk("mr_no_stale", oValid, 0);
      tick;
      chk("mr_no_stale2", oValid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
